// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle for wide_add_sequencer.
// WIDE_ADD_SUB_EN adds the in_sub operand qualifier.
interface wide_add_sequencer_if #(
  parameter int unsigned BYTES = 4
);
  localparam int unsigned W = 8 * BYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
`ifdef WIDE_ADD_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

`ifdef WIDE_ADD_SUB_EN
  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`else
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`endif
endinterface

// File: rtl/wide_add_sequencer.sv
// Byte-serial wide adder built around an external 8-bit adder with no carry input.
// WIDE_ADD_SUB_EN compiles in subtraction (A - B via ~B plus an initial carry).
module wide_add_sequencer #(
  parameter int unsigned BYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  wide_add_sequencer_if.slave       bus,
  output logic [7:0]                add_a,
  output logic [7:0]                add_b,
  input  logic [7:0]                add_sum,
  input  logic                      add_cout
);

  localparam int unsigned W  = 8 * BYTES;
  localparam int unsigned IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(BYTES - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StInc, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d, c1_q, c1_d, cout_q, cout_d;
  logic           in_ready_q, out_valid_q;
  logic           advance;
  logic [IW+2:0]  base;

  assign base = {idx_q, 3'b000};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c1_d    = c1_q;
    cout_d  = cout_q;
    advance = 1'b0;
    add_a   = 8'h00;
    add_b   = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d   = bus.in_a;
          idx_d = '0;
`ifdef WIDE_ADD_SUB_EN
          b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
          carry_d = bus.in_sub;
`else
          b_d     = bus.in_b;
          carry_d = 1'b0;
`endif
          state_d = StAdd;
        end
      end
      StAdd: begin
        add_a            = a_q[base +: 8];
        add_b            = b_q[base +: 8];
        sum_d[base +: 8] = add_sum;
        c1_d             = add_cout;
        // A pending carry needs a separate +1 pass; the adder has no carry input.
        if (carry_q) begin
          state_d = StInc;
        end else begin
          carry_d = add_cout;
          advance = 1'b1;
        end
      end
      StInc: begin
        add_a            = sum_q[base +: 8];
        add_b            = 8'h01;
        sum_d[base +: 8] = add_sum;
        carry_d          = c1_q | add_cout;
        advance          = 1'b1;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (idx_q == LastIdx) begin
        cout_d  = carry_d;
        state_d = StDone;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = StAdd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      c1_q        <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      c1_q        <= c1_d;
      cout_q      <= cout_d;
      in_ready_q  <= (state_d == StIdle);
      out_valid_q <= (state_d == StDone);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;

endmodule
